// File: rtl/iter_muldiv.sv
// Iterative RV32M-style multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and optional early-out for degenerate divides.
module iter_muldiv #(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     res_q, res_d;

    // Operand decode at accept
    logic            is_div, rs1_signed, rs2_signed, rs1_neg, rs2_neg;
    logic [XLEN-1:0] rs1_mag, rs2_mag, spec_res;
    logic            div_zero, sgn_ovf, special, res_neg;

    always_comb begin
        is_div     = funct3[2];
        rs1_signed = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
        rs2_signed = (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 ||
                      funct3 == 3'b110);
        rs1_neg    = rs1_signed && rs1[XLEN-1];
        rs2_neg    = rs2_signed && rs2[XLEN-1];
        rs1_mag    = rs1_neg ? ('0 - rs1) : rs1;
        rs2_mag    = rs2_neg ? ('0 - rs2) : rs2;
        div_zero   = is_div && (rs2 == '0);
        sgn_ovf    = is_div && !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (rs2 == '1);
        special    = div_zero || sgn_ovf;
        if (div_zero) begin
            spec_res = funct3[1] ? rs1 : '1;
        end else begin
            spec_res = funct3[1] ? '0 : rs1;
        end
        // Signed divide-by-zero must stay all ones, so the quotient is never negated there
        if (is_div) begin
            res_neg = funct3[1] ? rs1_neg : ((rs1_neg ^ rs2_neg) && !div_zero);
        end else begin
            res_neg = rs1_neg ^ rs2_neg;
        end
    end

    // One iteration of each datapath
    logic [XLEN:0]     add_sum, shifted, diff;
    logic [2*XLEN-1:0] prod_step, prod_fix;
    logic [XLEN-1:0]   quo_step, rem_step, quo_fix, rem_fix, fix_res;

    always_comb begin
        add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {add_sum, prod_q[XLEN-1:1]};
        shifted   = {rem_q, quo_q[XLEN-1]};
        diff      = shifted - {1'b0, mcand_q};
        quo_step  = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_step  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        prod_fix  = neg_q ? ('0 - prod_q) : prod_q;
        quo_fix   = neg_q ? ('0 - quo_q) : quo_q;
        rem_fix   = neg_q ? ('0 - rem_q) : rem_q;
        case (op_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        res_d   = res_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && !flush) begin
                    op_d    = funct3;
                    neg_d   = res_neg;
                    mcand_d = is_div ? rs2_mag : rs1_mag;
                    prod_d  = {{XLEN{1'b0}}, rs2_mag};
                    quo_d   = rs1_mag;
                    rem_d   = '0;
                    cnt_d   = CW'(XLEN - 1);
                    if (EARLY_OUT && special) begin
                        res_d   = spec_res;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (op_q[2]) begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                end else begin
                    prod_d = prod_step;
                end
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StFix: begin
                res_d   = fix_res;
                state_d = StDone;
            end
            StDone: begin
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign resp_data  = res_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv: two instances (early-out on and off) share stimulus
// and are checked against hand-computed results and latencies.
module tb_iter_muldiv;

    logic        clk, rst;
    logic        req_valid, flush, resp_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        req_ready_a, resp_valid_a, busy_a;
    logic        req_ready_b, resp_valid_b, busy_b;
    logic [31:0] resp_data_a, resp_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    iter_muldiv #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready_a),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .flush      (flush),
        .resp_valid (resp_valid_a),
        .resp_ready (resp_ready),
        .resp_data  (resp_data_a),
        .busy       (busy_a)
    );

    iter_muldiv #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready_b),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .flush      (flush),
        .resp_valid (resp_valid_b),
        .resp_ready (resp_ready),
        .resp_data  (resp_data_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request, deassert after the accept edge and scramble operands
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        funct3    = f3;
        rs1       = a;
        rs2       = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        funct3    = 3'($urandom);
        rs1       = $urandom;
        rs2       = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit special);
        int          lat_a, lat_b;
        logic [31:0] d_a, d_b;
        lat_a = 0;
        lat_b = 0;
        d_a   = '0;
        d_b   = '0;
        start_op(f3, a, b);
        for (int c = 1; c <= 40; c++) begin
            if (lat_a == 0 && resp_valid_a) begin
                lat_a = c;
                d_a   = resp_data_a;
            end
            if (lat_b == 0 && resp_valid_b) begin
                lat_b = c;
                d_b   = resp_data_b;
            end
            if (lat_a != 0 && lat_b != 0) break;
            @(posedge clk);
            #1;
        end
        check_eq({tag, " eo1 data"}, d_a, exp);
        check_eq({tag, " eo1 latency"}, lat_a, special ? 32'd1 : 32'd34);
        check_eq({tag, " eo0 data"}, d_b, exp);
        check_eq({tag, " eo0 latency"}, lat_b, 32'd34);
        @(posedge clk);
        #1;
        check_eq({tag, " idle after"}, {req_ready_a, req_ready_b}, 32'd3);
    endtask

    initial begin
        int          seen;
        logic [31:0] held;
        rst        = 1'b0;
        req_valid  = 1'b0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        funct3     = '0;
        rs1        = '0;
        rs2        = '0;
        #12;
        check_eq("reset resp_valid", {resp_valid_a, resp_valid_b}, 32'd0);
        check_eq("reset req_ready", {req_ready_a, req_ready_b}, 32'd3);
        check_eq("reset busy", {busy_a, busy_b}, 32'd0);
        check_eq("reset resp_data", resp_data_a | resp_data_b, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mul 7*-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("mulhu -1,-1", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("mulh -1,-1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_op("mulhsu -1,-1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("mulhu 2^31*4", 3'b011, 32'h80000000, 32'd4, 32'd2, 1'b0);
        run_op("mulh min*2", 3'b001, 32'h80000000, 32'd2, 32'hFFFFFFFF, 1'b0);
        run_op("div -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
        run_op("rem -7%2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
        run_op("div 7/-2", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
        run_op("rem 7%-2", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0);
        run_op("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op("remu 100%7", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
        run_op("divu 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);
        run_op("remu 5/0", 3'b111, 32'd5, 32'd0, 32'd5, 1'b1);
        run_op("div -7/0", 3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b1);
        run_op("rem -7/0", 3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b1);
        run_op("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1);

        // Flush in the tenth CALC cycle
        start_op(3'b000, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush busy", {busy_a, busy_b}, 32'd0);
        check_eq("flush req_ready", {req_ready_a, req_ready_b}, 32'd3);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid_a || resp_valid_b) seen++;
            @(posedge clk);
            #1;
        end
        check_eq("flush no response", seen, 32'd0);

        // Flush together with a request
        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        funct3    = 3'b000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check_eq("flush beats req", {busy_a, busy_b}, 32'd0);

        // Backpressure in DONE
        resp_ready = 1'b0;
        start_op(3'b101, 32'd100, 32'd7);
        seen = 0;
        for (int c = 1; c <= 40 && seen == 0; c++) begin
            if (resp_valid_b) seen = c;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("bp latency", seen, 32'd34);
        held = resp_data_b;
        check_eq("bp data", held, 32'd14);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_eq("bp data stable", resp_data_b, 32'd14);
            check_eq("bp valid/ready", {resp_valid_b, req_ready_b}, 32'd2);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp release", {resp_valid_a, resp_valid_b, req_ready_b}, 32'd1);

        // Asynchronous reset mid-CALC
        start_op(3'b000, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("arst busy", {busy_a, busy_b}, 32'd0);
        check_eq("arst resp_valid", {resp_valid_a, resp_valid_b}, 32'd0);
        check_eq("arst req_ready", {req_ready_a, req_ready_b}, 32'd3);
        check_eq("arst resp_data", resp_data_a | resp_data_b, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("post-reset mul", 3'b000, 32'd12, 32'd11, 32'd132, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_muldiv.md
ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits; legal values 8 to 64, even.
REQ-002 Parameter EARLY_OUT, default 1: 1 = divide-by-zero and signed-overflow results return without iterating; 0 = full latency for every op.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 funct3  input  3  op, RV32M encoding: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-008 rs1  input  XLEN  dividend / multiplicand.
REQ-009 rs2  input  XLEN  divisor / multiplier.
REQ-010 flush  input  1  abort in-flight op.
REQ-011 resp_valid  output  1  result present.
REQ-012 resp_ready  input  1  consumer takes result.
REQ-013 resp_data  output  XLEN  result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, CALC, FIX, DONE. req_ready is high only in IDLE; resp_valid is high only in DONE.
REQ-016 Accept = req_valid && req_ready && !flush at a clock edge; the unit registers funct3, rs1 and rs2 and moves to CALC.
REQ-017 Signedness: mul, mulh, div and rem treat both operands as signed; mulhsu treats rs1 as signed and rs2 as unsigned; mulhu, divu and remu treat both as unsigned.
REQ-018 Operands are converted to magnitudes at accept; the result sign is stored for the FIX state.
REQ-019 Multiply: shift-add, one multiplier bit per cycle, into a 2*XLEN product register.
REQ-020 Divide: restoring division, one quotient bit per cycle, with an (XLEN+1)-bit remainder.
REQ-021 CALC lasts exactly XLEN cycles, counted by an iteration counter that counts down from XLEN-1 to 0; the unit then moves to FIX.
REQ-022 FIX negates the product or the quotient when the result is negative; the remainder takes the sign of the dividend; the unit then moves to DONE.
REQ-023 Result selection: mul gives product[XLEN-1:0]; mulh, mulhsu and mulhu give product[2*XLEN-1:XLEN]; div and divu give the quotient; rem and remu give the remainder.
REQ-024 Latency: for an accept at edge T, resp_valid first rises after edge T+XLEN+2.
REQ-025 Divide by zero (rs2 == 0): div and divu give all ones; rem and remu give rs1.
REQ-026 Signed overflow (div or rem with rs1 = most-negative value and rs2 = all ones): div gives rs1; rem gives 0.
REQ-027 When EARLY_OUT = 1, the REQ-025 and REQ-026 cases go from IDLE directly to DONE, with resp_valid after edge T+1.
REQ-028 When EARLY_OUT = 0, the REQ-025 and REQ-026 cases produce the same values at the REQ-024 latency.
REQ-029 DONE holds resp_data stable until resp_valid && resp_ready; the unit then returns to IDLE.
REQ-030 No request is accepted in the same cycle as a response handshake.
REQ-031 flush high at an edge, in any state, forces IDLE at that edge and discards any result.
REQ-032 flush has priority over req_valid and over resp_ready in the same cycle.
REQ-033 Operand values are ignored outside the accept cycle.

Reset
REQ-034 While rst is low the unit is asynchronously placed in IDLE, regardless of clk.
REQ-035 Reset values: resp_valid 0, resp_data 0, busy 0, req_ready 1, iteration counter 0, product, quotient and remainder registers 0.
REQ-036 Assertion of rst mid-operation discards the operation; no response is produced for it.

Verification (XLEN=32)
REQ-037 mul rs1=7, rs2=0xFFFFFFFD -> resp_data 0xFFFFFFEB; resp_valid rises exactly 34 cycles after accept.
REQ-038 rs1 = rs2 = 0xFFFFFFFF: mulhu -> 0xFFFFFFFE; mulh -> 0x00000000; mulhsu -> 0xFFFFFFFF.
REQ-039 Signed division: div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; rem 0xFFFFFFF9 % 2 -> 0xFFFFFFFF.
REQ-040 Boundary cases, EARLY_OUT=1: divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5; div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem of the same operands -> 0; each with resp_valid 1 cycle after accept. Same values at 34 cycles with EARLY_OUT=0.
REQ-041 Flush and backpressure: flush at cycle 10 of CALC -> IDLE next cycle, no resp_valid; resp_ready held low 5 cycles in DONE -> resp_data unchanged, req_ready low; simultaneous flush and req_valid -> no accept.
REQ-042 Reset: rst low mid-CALC -> outputs take REQ-035 values without a clock edge; the next request completes correctly.
